// File: rtl/pred_sse.sv
// pred_sse: row-serial residual and SSE stage behind the 16x16 intra
// predictors. One block row per cycle; start/done handshake matches the
// predictors so their done can launch this block directly.

// Per-column lane: signed difference and its square.
module pred_sse_lane #(
  parameter int BW = 8
) (
  input  logic [BW-1:0]   s,
  input  logic [BW-1:0]   p,
  output logic [BW:0]     d,
  output logic [2*BW+1:0] sq
);
  logic signed [BW:0]     ds;
  logic signed [2*BW+1:0] prod;

  // zero-extend both pixels so the difference spans [-255,255]; square it signed
  always_comb begin
    ds   = $signed({1'b0, s}) - $signed({1'b0, p});
    prod = ds * ds;
  end

  assign d  = ds;
  assign sq = prod;
endmodule

module pred_sse #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 16,
  parameter int ROW_W      = 5,
  parameter int SSE_W      = 2*BIT_WIDTH+8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]      src,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]      pred,
  output logic [(BIT_WIDTH+1)*BLOCK_SIZE*BLOCK_SIZE-1:0]  resid,
  output logic [SSE_W-1:0]                                sse,
  output logic                                            busy,
  output logic                                            done
);
  localparam int RI   = $clog2(BLOCK_SIZE);
  localparam int SQ_W = 2*BIT_WIDTH+2;
  localparam int RS_W = 2*BIT_WIDTH+4;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    CALC = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t state, state_nxt;

  logic [ROW_W-1:0] row;
  logic [RI-1:0]    row_i;
  logic [SSE_W-1:0] acc;
  logic             last_row;

  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][BIT_WIDTH-1:0] src_a, pred_a;
  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][BIT_WIDTH:0]   res_q;
  logic [BLOCK_SIZE-1:0][BIT_WIDTH:0]                   d_row;
  logic [BLOCK_SIZE-1:0][SQ_W-1:0]                      sq_row;
  logic [RS_W-1:0]                                      rowsum;

  assign src_a    = src;
  assign pred_a   = pred;
  assign row_i    = row[RI-1:0];
  assign last_row = (row == ROW_W'(BLOCK_SIZE-1));
  assign resid    = res_q;
  assign busy     = (state != IDLE);

  // one lane per column, all fed from the currently selected row
  for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_lane
    pred_sse_lane #(.BW(BIT_WIDTH)) u_lane (
      .s  (src_a[row_i][c]),
      .p  (pred_a[row_i][c]),
      .d  (d_row[c]),
      .sq (sq_row[c])
    );
  end

  // adder tree over the row's squared differences
  always_comb begin
    rowsum = '0;
    for (int c = 0; c < BLOCK_SIZE; c++)
      rowsum = rowsum + RS_W'(sq_row[c]);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; any non-legal encoding falls back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_row) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // row counter, accumulator, residual rows and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= '0;
      acc   <= '0;
      sse   <= '0;
      res_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          row <= '0;
          acc <= '0;
        end
        CALC: begin
          res_q[row_i] <= d_row;
          acc          <= acc + SSE_W'(rowsum);
          row          <= row + 1'b1;
        end
        DONE:    sse <= acc;
        default: ;
      endcase
    end
  end
endmodule
